// File: rtl/in_bus_pkg.sv
// Shared types and address-field helpers for the in_bus arbiter slice.
package in_bus_pkg;

    typedef enum logic [1:0] {
        DIS   = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2
    } arb_state_e;

    localparam int SW_ADDR_MSB  = 7;
    localparam int SW_ADDR_LSB  = 5;
    localparam int REG_ADDR_MSB = 4;
    localparam int REG_ADDR_LSB = 0;
    localparam int OP_ID_W      = 8;

    function automatic logic [2:0] sw_field(input logic [7:0] addr);
        return addr[SW_ADDR_MSB:SW_ADDR_LSB];
    endfunction

    function automatic logic sw_valid(input logic [2:0] sw, input int n);
        return int'(sw) < n;
    endfunction

endpackage

// File: rtl/in_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping to 0.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && elig[j]) begin
                found     = 1'b1;
                idx       = IW'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/in_bus_arbiter.sv
// Round-robin arbiter sharing in_bus between host requesters.
// Define IN_ARB_ID_TAG_EN to tag op_id with the winner index.
module in_bus_arbiter
    import in_bus_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       arb_en,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         req_wr_rd,
    input  logic [NUM_REQ*8-1:0]       req_addr,
    input  logic [NUM_REQ*W_WIDTH-1:0] req_data,
    input  logic [NUM_SW_INST-1:0]     fifo_afull,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [NUM_REQ-1:0]         err,
    output logic                       en_in,
    output logic                       valid,
    output logic                       wr_rd_op,
    output logic [OP_ID_W-1:0]         op_id,
    output logic [7:0]                 addr_in,
    output logic [W_WIDTH-1:0]         wr_data_in,
    output logic                       busy
);

    localparam int IW = $clog2(NUM_REQ);
`ifdef IN_ARB_ID_TAG_EN
    localparam int CNT_W = 5;
`else
    localparam int CNT_W = OP_ID_W;
`endif

    arb_state_e         state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      nxt_ptr;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] pick;
    logic               found;
    logic [7:0]         afull_ext;
    logic [7:0]         w_addr;
    logic [W_WIDTH-1:0] w_data;
    logic               w_ok;
    logic [CNT_W-1:0]   cnt;
    logic [OP_ID_W-1:0] new_id;

    assign afull_ext = 8'(fifo_afull);

    // gnt is the previous cycle's grant: masks a requester still
    // holding req while it reacts to its own accept pulse.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = req[i] & ~gnt[i]
                & (~sw_valid(sw_field(req_addr[8*i +: 8]), NUM_SW_INST)
                   | ~afull_ext[sw_field(req_addr[8*i +: 8])]);
        end
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .elig   (elig),
        .ptr    (rr_ptr),
        .onehot (pick),
        .idx    (idx),
        .found  (found)
    );

    assign nxt_ptr = (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    assign w_addr  = req_addr[int'(idx)*8 +: 8];
    assign w_data  = req_data[int'(idx)*W_WIDTH +: W_WIDTH];
    assign w_ok    = sw_valid(sw_field(w_addr), NUM_SW_INST);

`ifdef IN_ARB_ID_TAG_EN
    assign new_id = {3'(idx), cnt};
`else
    assign new_id = cnt;
`endif

    assign en_in = (state != DIS);
    assign busy  = (state == ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DIS;
            rr_ptr     <= '0;
            cnt        <= '0;
            gnt        <= '0;
            err        <= '0;
            valid      <= 1'b0;
            wr_rd_op   <= 1'b0;
            op_id      <= '0;
            addr_in    <= '0;
            wr_data_in <= '0;
        end else begin
            gnt   <= '0;
            err   <= '0;
            valid <= 1'b0;
            if (!arb_en) begin
                state <= DIS;
            end else begin
                unique case (state)
                    DIS: state <= IDLE;
                    IDLE, ISSUE: begin
                        if (found) begin
                            state  <= ISSUE;
                            gnt    <= pick;
                            rr_ptr <= nxt_ptr;
                            if (w_ok) begin
                                valid      <= 1'b1;
                                wr_rd_op   <= req_wr_rd[idx];
                                addr_in    <= w_addr;
                                wr_data_in <= w_data;
                                op_id      <= new_id;
                                cnt        <= cnt + 1'b1;
                            end else begin
                                err <= pick;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= DIS;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_in_bus_arbiter.sv
// Randomized scoreboard bench for in_bus_arbiter against a queue-based
// reference model of the arbitration rules.
module tb_in_bus_arbiter;

    localparam int N  = 4;
    localparam int NS = 5;
    localparam int W  = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         arb_en;
    logic [N-1:0] req;
    logic [N-1:0] req_wr_rd;
    logic [N*8-1:0] req_addr;
    logic [N*W-1:0] req_data;
    logic [NS-1:0]  fifo_afull;
    logic [N-1:0] gnt;
    logic [N-1:0] err;
    logic         en_in;
    logic         valid;
    logic         wr_rd_op;
    logic [7:0]   op_id;
    logic [7:0]   addr_in;
    logic [W-1:0] wr_data_in;
    logic         busy;

    in_bus_arbiter #(
        .NUM_REQ     (N),
        .NUM_SW_INST (NS),
        .W_WIDTH     (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_en     (arb_en),
        .req        (req),
        .req_wr_rd  (req_wr_rd),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .fifo_afull (fifo_afull),
        .gnt        (gnt),
        .err        (err),
        .en_in      (en_in),
        .valid      (valid),
        .wr_rd_op   (wr_rd_op),
        .op_id      (op_id),
        .addr_in    (addr_in),
        .wr_data_in (wr_data_in),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] gnt;
        logic [N-1:0] err;
        logic [7:0]   op_id;
        logic [7:0]   addr;
        logic [W-1:0] data;
        logic         wr;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Reference model: 0=disabled, 1=idle, 2=issuing
    int           m_st;
    int           m_ptr;
    int           m_cnt;
    logic [N-1:0] m_last;
    logic [7:0]   m_addr;
    logic [W-1:0] m_data;
    logic         m_wr;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st   = 0;
        m_ptr  = 0;
        m_cnt  = 0;
        m_last = '0;
        m_addr = '0;
        m_data = '0;
        m_wr   = 1'b0;
    endtask

    // Predicts what the next rising edge does with the current inputs.
    task automatic model_step();
        int   w;
        int   sw;
        exp_t e;
        logic [7:0] tag;
        w = -1;
        if (!arb_en) begin
            m_st   = 0;
            m_last = '0;
        end else if (m_st == 0) begin
            m_st   = 1;
            m_last = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int i;
                i  = (m_ptr + k) % N;
                sw = int'(req_addr[8*i+5 +: 3]);
                if (w < 0 && req[i] && !m_last[i]
                    && (sw >= NS || !fifo_afull[sw]))
                    w = i;
            end
            if (w < 0) begin
                m_st   = 1;
                m_last = '0;
            end else begin
                sw      = int'(req_addr[8*w+5 +: 3]);
                e.gnt   = '0;
                e.gnt[w] = 1'b1;
                e.err   = '0;
                e.op_id = '0;
                if (sw >= NS) begin
                    e.err[w] = 1'b1;
                end else begin
`ifdef IN_ARB_ID_TAG_EN
                    tag     = 8'(w);
                    e.op_id = {tag[2:0], 5'(m_cnt)};
                    m_cnt   = (m_cnt + 1) % 32;
`else
                    tag     = 8'(m_cnt);
                    e.op_id = tag;
                    m_cnt   = (m_cnt + 1) % 256;
`endif
                    m_addr = req_addr[8*w +: 8];
                    m_data = req_data[W*w +: W];
                    m_wr   = req_wr_rd[w];
                end
                e.addr = m_addr;
                e.data = m_data;
                e.wr   = m_wr;
                q.push_back(e);
                m_last = e.gnt;
                m_ptr  = (w + 1) % N;
                m_st   = 2;
            end
        end
    endtask

    task automatic step_cycle();
        model_step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [7:0] rand_addr();
        logic [2:0] sw;
        logic [4:0] rg;
        if ($urandom_range(0, 5) == 0) sw = 3'($urandom_range(NS, 7));
        else sw = 3'($urandom_range(0, NS - 1));
        rg = 5'($urandom);
        return {sw, rg};
    endfunction

    task automatic new_req(input int i);
        req[i]          = 1'b1;
        req_wr_rd[i]    = 1'($urandom);
        req_addr[8*i +: 8] = rand_addr();
        req_data[W*i +: W] = W'($urandom);
    endtask

    // Monitor: per-cycle status plus scoreboard pop on any accept.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            exp_t e;
            check("en_in", 64'(en_in), 64'(m_st != 0));
            check("busy", 64'(busy), 64'(m_st == 2));
            check("payload_hold", {wr_rd_op, addr_in, wr_data_in},
                  {m_wr, m_addr, m_data});
            if (gnt != '0 || err != '0 || valid) begin
                if (q.size() == 0) begin
                    check("unexpected_grant", {gnt, err, 3'b0, valid}, '0);
                end else begin
                    e = q.pop_front();
                    check("gnt", 64'(gnt), 64'(e.gnt));
                    check("err", 64'(err), 64'(e.err));
                    check("valid", 64'(valid), 64'(e.err == '0));
                    if (e.err == '0)
                        check("op_id", 64'(op_id), 64'(e.op_id));
                end
            end
        end
    end

    int dis_left;

    initial begin
        rst_n      = 1'b0;
        arb_en     = 1'b0;
        req        = '0;
        req_wr_rd  = '0;
        req_addr   = '0;
        req_data   = '0;
        fifo_afull = '0;
        model_reset();
        #12;
        check("reset_outputs",
              {gnt, err, en_in, valid, wr_rd_op, op_id, addr_in,
               wr_data_in, busy}, '0);
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single write from r1
        arb_en        = 1'b1;
        req[1]        = 1'b1;
        req_wr_rd[1]  = 1'b1;
        req_addr[15:8] = 8'h43;
        req_data[15:8] = 8'hA5;
        step_cycle();
        step_cycle();
        check("t1_grant", {gnt, valid, addr_in, wr_data_in, op_id},
              {4'b0010, 1'b1, 8'h43, 8'hA5, 8'h00});
        req = '0;
        step_cycle();

        // All four requesting continuously
        for (int i = 0; i < N; i++) begin
            req_addr[8*i +: 8] = {3'(i), 5'(i)};
            req_data[W*i +: W] = W'(8'h10 + i);
        end
        req = 4'b1111;
        for (int c = 0; c < 6; c++) step_cycle();
        req = '0;
        step_cycle();

        // Almost-full switch blocks r0 while r2 proceeds
        req_addr[7:0]   = 8'h41;
        req_addr[23:16] = 8'h02;
        fifo_afull      = 5'b00100;
        req[0]          = 1'b1;
        req[2]          = 1'b1;
        step_cycle();
        check("t3_r2_only", 64'(gnt), 64'(4'b0100));
        req[2] = 1'b0;
        step_cycle();
        check("t3_r0_blocked", 64'(gnt), 64'(4'b0000));
        fifo_afull = '0;
        step_cycle();
        check("t3_r0_after", 64'(gnt), 64'(4'b0001));
        req = '0;
        step_cycle();

        // Out-of-range switch
        req_addr[31:24] = 8'hE0;
        req[3]          = 1'b1;
        step_cycle();
        check("t4_err", {gnt, err, valid}, {4'b1000, 4'b1000, 1'b0});
        req = '0;
        step_cycle();

        // Disable during a stream
        req = 4'b0111;
        step_cycle();
        step_cycle();
        arb_en = 1'b0;
        step_cycle();
        step_cycle();
        check("t6_parked", {en_in, gnt, valid}, '0);
        arb_en = 1'b1;
        req    = '0;
        step_cycle();

        // Randomized traffic, with one async reset mid-issue
        dis_left = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_last[i]) begin
                    req[i] = 1'b0;
                    if ($urandom_range(0, 1) == 0) new_req(i);
                end else if (req[i]) begin
                    if ($urandom_range(0, 49) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i);
                end
            end
            for (int s = 0; s < NS; s++)
                fifo_afull[s] = ($urandom_range(0, 3) == 0);
            if (dis_left > 0) begin
                dis_left--;
                arb_en = (dis_left == 0);
            end else if ($urandom_range(0, 99) == 0) begin
                dis_left = $urandom_range(1, 4);
                arb_en   = 1'b0;
            end
            step_cycle();
            if (c >= 2000 && c < 2100 && m_st == 2 && rst_n) begin
                rst_n = 1'b0;
                #1;
                check("async_reset",
                      {gnt, err, en_in, valid, wr_rd_op, op_id, addr_in,
                       wr_data_in, busy}, '0);
                q.delete();
                model_reset();
                c = 2100;
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        arb_en = 1'b1;
        req    = '0;
        step_cycle();
        step_cycle();
        check("queue_drained", 64'(q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
